mmm_mod_inv2k: RTL and testbench

- Runtime-configurable modular inverse modulo a power of two.
- Computes y = n^-1 mod 2^k, or the Montgomery constant n' = -n^-1 mod 2^k in negate mode, for any k in 1..WIDTH.
- Sits ahead of the Montgomery multiplier datapath and supplies n' per modulus.
- Bit-serial Hensel lifting, one adder per cycle, valid/ready handshake on both sides, error flag for illegal operands.

---
 rtl/mmm_mod_inv2k.sv | 121 ++++++++++++
 tb/tb_mmm_mod_inv2k.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmm_mod_inv2k.sv
// Bit-serial modular inverse modulo 2^k (Hensel lifting), optionally negated to
// produce the Montgomery constant n' = -n^-1 mod 2^k for the multiplier datapath.
module mmm_mod_inv2k #(
   parameter int WIDTH = 260,
   parameter int KW    = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_n,
   input  logic [KW-1:0]    i_k,
   input  logic             i_neg,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_res,
   output logic             o_err
);

   typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mask_r, n_sh, t, y;
   logic [KW-1:0]    k_r, i_r;
   logic             neg_r, err_r;

   logic             accept, req_illegal, last_bit;
   logic [WIDTH-1:0] req_mask, req_n;

   assign accept      = i_valid & o_ready;
   assign req_illegal = ~i_n[0] | (i_k == '0) | (i_k > KW'(WIDTH));
   assign last_bit    = (i_r == k_r - KW'(1));
   assign req_n       = i_n & req_mask;

   // k = WIDTH must yield all ones without relying on a full-width shift.
   always_comb begin
      req_mask = '1;
      if (i_k < KW'(WIDTH))
         req_mask = ~({WIDTH{1'b1}} << i_k);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (req_illegal || i_k == KW'(1)) ? FIN : CALC;
         CALC: if (last_bit) state_nxt = FIN;
         FIN:  state_nxt = DONE;
         DONE: if (i_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state == IDLE);
   end

   // n_sh tracks n << i so each CALC step needs only one adder and no barrel shifter.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         mask_r  <= '0;
         n_sh    <= '0;
         t       <= '0;
         y       <= '0;
         k_r     <= '0;
         i_r     <= '0;
         neg_r   <= 1'b0;
         err_r   <= 1'b0;
         o_res   <= '0;
         o_valid <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mask_r <= req_mask;
                  n_sh   <= req_n << 1;
                  t      <= req_n;
                  y      <= WIDTH'(1);
                  i_r    <= KW'(1);
                  k_r    <= i_k;
                  neg_r  <= i_neg;
                  err_r  <= req_illegal;
               end
            end
            CALC: begin
               if (t[i_r]) begin
                  y[i_r] <= 1'b1;
                  t      <= t + n_sh;
               end
               n_sh <= n_sh << 1;
               i_r  <= i_r + KW'(1);
            end
            FIN: begin
               if (err_r)
                  o_res <= '0;
               else if (neg_r)
                  o_res <= (~y + WIDTH'(1)) & mask_r;
               else
                  o_res <= y & mask_r;
               o_err   <= err_r;
               o_valid <= 1'b1;
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mmm_mod_inv2k.sv
// Self-checking bench for mmm_mod_inv2k: directed vector table, handshake and
// reset sequences, and a randomized regression against a Newton-iteration model.
module tb_mmm_mod_inv2k;

   localparam int WIDTH = 260;
   localparam int KW    = $clog2(WIDTH + 1);

   logic             i_clk = 1'b0;
   logic             i_rstn;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_n;
   logic [KW-1:0]    i_k;
   logic             i_neg;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_res;
   logic             o_err;

   int checks   = 0;
   int failures = 0;

   mmm_mod_inv2k #(.WIDTH(WIDTH), .KW(KW)) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_n     (i_n),
      .i_k     (i_k),
      .i_neg   (i_neg),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [WIDTH-1:0] n;
      int               k;
      bit               neg;
      logic [WIDTH-1:0] exp_res;
      bit               exp_err;
      int               exp_lat;
   } vec_t;

   function automatic logic [WIDTH-1:0] mask_of(input int k);
      logic [WIDTH-1:0] m;
      for (int j = 0; j < WIDTH; j++) m[j] = (j < k);
      return m;
   endfunction

   function automatic bit model_err(input logic [WIDTH-1:0] n, input int k);
      return (k == 0) || (k > WIDTH) || (n[0] == 1'b0);
   endfunction

   // Newton iteration y <- y*(2 - n*y) doubles the correct low bits each step.
   function automatic logic [WIDTH-1:0] model_res(input logic [WIDTH-1:0] n, input int k, input bit neg);
      logic [WIDTH-1:0] m, nm, y;
      if (model_err(n, k)) return '0;
      m  = mask_of(k);
      nm = n & m;
      y  = nm;
      for (int it = 0; it < 9; it++) y = y * (WIDTH'(2) - nm * y);
      y = y & m;
      if (neg) y = (WIDTH'(0) - y) & m;
      return y;
   endfunction

   function automatic logic [WIDTH-1:0] rand_wide();
      logic [WIDTH-1:0] v;
      for (int j = 0; j < WIDTH; j++) v[j] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] n, input int k, input bit neg);
      int cnt;
      i_n     = n;
      i_k     = KW'(k);
      i_neg   = neg;
      i_valid = 1'b1;
      cnt     = 0;
      while (!o_ready && cnt < 2 * WIDTH + 50) begin
         @(posedge i_clk); #1;
         cnt++;
      end
      if (!o_ready) checkOutput("accept_timeout", WIDTH'(o_ready), WIDTH'(1));
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_n     = rand_wide();
      i_k     = KW'($urandom);
      i_neg   = ~neg;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!o_valid && lat < WIDTH + 20) begin
         @(posedge i_clk); #1;
         lat++;
      end
      if (!o_valid) checkOutput("valid_timeout", WIDTH'(o_valid), WIDTH'(1));
   endtask

   task automatic handoff();
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      checkOutput("handoff_valid", WIDTH'(o_valid), WIDTH'(0));
      checkOutput("handoff_ready", WIDTH'(o_ready), WIDTH'(1));
   endtask

   task automatic run_vector(input string name, input vec_t v, input bit check_prop);
      int lat;
      logic [WIDTH-1:0] m, prod;
      applyStimulus(v.n, v.k, v.neg);
      wait_valid(lat);
      checkOutput({name, "_res"}, o_res, v.exp_res);
      checkOutput({name, "_err"}, WIDTH'(o_err), WIDTH'(v.exp_err));
      checkOutput({name, "_lat"}, WIDTH'(lat), WIDTH'(v.exp_lat));
      if (check_prop && !v.exp_err) begin
         m    = mask_of(v.k);
         prod = ((v.n & m) * o_res) & m;
         checkOutput({name, "_prod"}, prod, v.neg ? m : WIDTH'(1));
      end
      handoff();
   endtask

   vec_t             vecs[$];
   vec_t             v;
   logic [WIDTH-1:0] all_ones;
   logic [WIDTH-1:0] held_res;
   int               lat;
   int               seen_valid;

   initial begin
      all_ones = '1;
      vecs.push_back('{WIDTH'(3),           8,         1'b0, WIDTH'(171),    1'b0, 8});
      vecs.push_back('{WIDTH'(3),           8,         1'b1, WIDTH'(85),     1'b0, 8});
      vecs.push_back('{WIDTH'(3),           16,        1'b0, WIDTH'('hAAAB), 1'b0, 16});
      vecs.push_back('{all_ones,            16,        1'b1, WIDTH'(1),      1'b0, 16});
      vecs.push_back('{WIDTH'(1),           WIDTH,     1'b0, WIDTH'(1),      1'b0, WIDTH});
      vecs.push_back('{WIDTH'(1),           WIDTH,     1'b1, all_ones,       1'b0, WIDTH});
      vecs.push_back('{WIDTH'(1),           1,         1'b0, WIDTH'(1),      1'b0, 1});
      vecs.push_back('{WIDTH'(1),           1,         1'b1, WIDTH'(1),      1'b0, 1});
      vecs.push_back('{WIDTH'(6),           8,         1'b0, WIDTH'(0),      1'b1, 1});
      vecs.push_back('{WIDTH'(3),           0,         1'b0, WIDTH'(0),      1'b1, 1});
      vecs.push_back('{WIDTH'(3),           WIDTH + 1, 1'b1, WIDTH'(0),      1'b1, 1});

      i_rstn  = 1'b0;
      i_valid = 1'b0;
      i_n     = '0;
      i_k     = '0;
      i_neg   = 1'b0;
      i_ready = 1'b0;
      #2;
      checkOutput("reset_ready", WIDTH'(o_ready), WIDTH'(1));
      checkOutput("reset_valid", WIDTH'(o_valid), WIDTH'(0));
      checkOutput("reset_err",   WIDTH'(o_err),   WIDTH'(0));
      checkOutput("reset_res",   o_res,           WIDTH'(0));
      #10;
      i_rstn = 1'b1;
      @(posedge i_clk); #1;

      foreach (vecs[idx]) run_vector($sformatf("vec%0d", idx), vecs[idx], 1'b1);

      // Backpressure: result held while i_ready=0, queued request waits for IDLE.
      applyStimulus(WIDTH'(3), 8, 1'b0);
      wait_valid(lat);
      held_res = o_res;
      checkOutput("bp_res", held_res, WIDTH'(171));
      i_n     = WIDTH'(5);
      i_k     = KW'(8);
      i_neg   = 1'b1;
      i_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge i_clk); #1;
         checkOutput("bp_hold_valid", WIDTH'(o_valid), WIDTH'(1));
         checkOutput("bp_hold_res",   o_res,           held_res);
         checkOutput("bp_hold_err",   WIDTH'(o_err),   WIDTH'(0));
         checkOutput("bp_hold_ready", WIDTH'(o_ready), WIDTH'(0));
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      checkOutput("bp_release_valid", WIDTH'(o_valid), WIDTH'(0));
      checkOutput("bp_release_ready", WIDTH'(o_ready), WIDTH'(1));
      checkOutput("bp_release_res",   o_res,           held_res);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checkOutput("bp_second_accepted", WIDTH'(o_ready), WIDTH'(0));
      wait_valid(lat);
      checkOutput("bp_second_res", o_res, model_res(WIDTH'(5), 8, 1'b1));
      checkOutput("bp_second_lat", WIDTH'(lat), WIDTH'(8));
      handoff();

      // Reset mid-calculation aborts the request without producing a result.
      applyStimulus(rand_wide() | WIDTH'(1), 64, 1'b0);
      repeat (20) @(posedge i_clk);
      #1;
      i_rstn = 1'b0;
      #1;
      checkOutput("rst_mid_valid", WIDTH'(o_valid), WIDTH'(0));
      checkOutput("rst_mid_ready", WIDTH'(o_ready), WIDTH'(1));
      #2;
      i_rstn = 1'b1;
      seen_valid = 0;
      for (int c = 0; c < 70; c++) begin
         @(posedge i_clk); #1;
         if (o_valid) seen_valid++;
      end
      checkOutput("rst_no_result", WIDTH'(seen_valid), WIDTH'(0));
      v = '{WIDTH'(3), 8, 1'b0, WIDTH'(171), 1'b0, 8};
      run_vector("post_rst", v, 1'b1);

      // Randomized regression against the Newton-iteration model.
      for (int r = 0; r < 40; r++) begin
         v.n   = rand_wide();
         v.neg = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       begin v.k = 0;                                  v.n[0] = 1'b1; end
            1:       begin v.k = $urandom_range(WIDTH + 1, 2**KW - 1); v.n[0] = 1'b1; end
            2:       begin v.k = $urandom_range(1, WIDTH);           v.n[0] = 1'b0; end
            default: begin v.k = $urandom_range(1, WIDTH);           v.n[0] = 1'b1; end
         endcase
         v.exp_err = model_err(v.n, v.k);
         v.exp_res = model_res(v.n, v.k, v.neg);
         v.exp_lat = v.exp_err ? 1 : v.k;
         run_vector($sformatf("rand%0d_k%0d", r, v.k), v, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
